frame_motion_sched: RTL and testbench
=====================================

Name: frame_motion_sched

Overview:
Frame-synchronous scheduler for the moving object drawn by the pixel generator. It watches the scan coordinates from the VGA timing block and detects the start of vertical blanking. Every FRAME_DIV-th frame it sequences one position update with wall bounce, then presents the new position to the pixel generator. Position only changes during blanking, so there is no tearing, and motion speed does not depend on the pixel clock.

Parameters:
H_VISIBLE, 640, visible pixels per line
V_VISIBLE, 480, visible lines per frame
OBJ_W, 20, object width in pixels
OBJ_H, 30, object height in lines
SPEED, 1, pixels moved per axis per update; must be at least 1 and less than both H_VISIBLE-OBJ_W and V_VISIBLE-OBJ_H
FRAME_DIV, 1, frames per update; must be at least 1

Ports:
clk_i  in  1  pixel clock
reset_i  in  1  asynchronous, active-high reset
x_i  in  10  current scan column from the VGA timing block
y_i  in  10  current scan line from the VGA timing block
run_i  in  1  1 = motion enabled; sampled only on the vblank event
x_o  out  10  object left edge
y_o  out  10  object top edge
x_dir_o  out  1  1 = moving right, 0 = moving left
y_dir_o  out  1  1 = moving down, 0 = moving up
update_o  out  1  one-cycle pulse when x_o/y_o change
bounce_o  out  1  one-cycle pulse, coincident with update_o, when either axis reversed

Behaviour:
- Reset is asynchronous, active-high, on clk_i. Reset values: x_o=0, y_o=0, x_dir_o=1, y_dir_o=1, update_o=0, bounce_o=0, state=S_WAIT, frame_cnt=0.
- Vblank event: x_i==0 && y_i==V_VISIBLE at a rising edge while the previous edge did not see that match. Rising-edge qualified, so at most one event per frame even if the coordinates stall.
- FSM states: S_WAIT, S_CALC, S_COMMIT.
- S_WAIT, no event: hold.
- S_WAIT, event, frame_cnt<FRAME_DIV-1: frame_cnt++, stay in S_WAIT.
- S_WAIT, event, frame_cnt==FRAME_DIV-1: frame_cnt=0; go to S_CALC if run_i=1, else stay in S_WAIT. With run_i=0 the frame counter still runs.
- S_CALC (one cycle) computes next position in 11-bit unsigned arithmetic, no wrap. Let XMAX=H_VISIBLE-OBJ_W, YMAX=V_VISIBLE-OBJ_H.
  - dir=1: if pos+SPEED >= MAX, then next=MAX, dir flips to 0, bounce. Else next=pos+SPEED.
  - dir=0: if pos <= SPEED, then next=0, dir flips to 1, bounce. Else next=pos-SPEED.
  - The same rule applies to y with YMAX. Axes are evaluated independently.
  - Go to S_COMMIT.
- S_COMMIT: register x_o, y_o, dirs; assert update_o=1; assert bounce_o=1 if either axis bounced. Return to S_WAIT.
- Latency: the event is sampled at edge E0. Outputs change at edge E0+2. update_o and bounce_o are high for exactly the cycle after E0+2.
- Both axes bouncing in the same update produce a single bounce_o pulse and both directions flip.
- run_i changes during S_CALC or S_COMMIT have no effect on the pending update.
- A vblank event arriving in S_CALC or S_COMMIT is ignored and frame_cnt is not advanced. This cannot occur with real timing.
- Reset asserted mid-update discards the pending update; all outputs return to their reset values immediately.
- Outputs are stable at all times other than the commit edge. Outputs are fully registered.

Optional Feature:
FRAME_SCHED_STEP_EN
- Defined: adds input port step_i (1 bit). A step_i pulse sets a sticky step_arm flag. On the next update-eligible event with run_i=0 and step_arm=1, exactly one update runs and step_arm clears. With run_i=1, step_arm is ignored and left set. Reset clears step_arm.
- Undefined: no step_i port, no step_arm logic; behaviour is exactly as above.

Test Plan:
- Reset: assert reset_i mid-frame -> x_o=0, y_o=0, x_dir_o=1, y_dir_o=1, update_o=0, bounce_o=0, all asynchronously.
- Basic motion (defaults, run_i=1): one event at x_i=0, y_i=480 -> x_o=1, y_o=1 two edges later; update_o high exactly 1 cycle; bounce_o=0. Holding x_i=0, y_i=480 for 5 cycles -> only one update.
- Wall bounce: 450 events -> y_o=450, y_dir_o=0, bounce_o=1. Event 451 -> y_o=449. Event 620 -> x_o=620, x_dir_o=0, bounce_o=1.
- Corner: preload x=619, y=449 moving +,+ with SPEED=1 -> next update gives x_o=620, y_o=450, both dirs 0, one bounce_o pulse.
- FRAME_DIV=4, run_i=1: 8 events -> updates only on events 4 and 8. run_i=0 on event 4 -> no update, and event 8 still updates.
- Step (FRAME_SCHED_STEP_EN, run_i=0): step_i pulse then 3 events -> exactly one update on event 1. Reset between step_i and event -> no update.

Source files
------------

// File: rtl/frame_motion_sched.sv
// Frame-synchronous motion scheduler: one bounced position update per FRAME_DIV frames,
// applied during vertical blanking. Optional single-step input under `FRAME_SCHED_STEP_EN.
module frame_motion_sched #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int OBJ_W     = 20,
  parameter int OBJ_H     = 30,
  parameter int SPEED     = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  input  logic       run_i,
`ifdef FRAME_SCHED_STEP_EN
  input  logic       step_i,
`endif
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       x_dir_o,
  output logic       y_dir_o,
  output logic       update_o,
  output logic       bounce_o
);

  localparam int              FC_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);
  localparam logic [10:0]     XMAX    = 11'(H_VISIBLE - OBJ_W);
  localparam logic [10:0]     YMAX    = 11'(V_VISIBLE - OBJ_H);
  localparam logic [10:0]     SPD     = 11'(SPEED);

  typedef enum logic [1:0] {S_WAIT, S_CALC, S_COMMIT} state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       flip;
  } axis_t;

  // One axis of motion, evaluated in 11 bits so pos+SPEED cannot wrap.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [10:0] max);
    axis_t       r;
    logic [10:0] p;
    logic [10:0] t;
    p      = {1'b0, pos};
    t      = '0;
    r.pos  = pos;
    r.dir  = dir;
    r.flip = 1'b0;
    if (dir) begin
      t = p + SPD;
      if (t >= max) begin
        r.pos  = max[9:0];
        r.dir  = 1'b0;
        r.flip = 1'b1;
      end else begin
        r.pos = t[9:0];
      end
    end else begin
      if (p <= SPD) begin
        r.pos  = '0;
        r.dir  = 1'b1;
        r.flip = 1'b1;
      end else begin
        t     = p - SPD;
        r.pos = t[9:0];
      end
    end
    return r;
  endfunction

  state_t          state;
  logic [FC_W-1:0] frame_cnt;
  logic            match;
  logic            match_q;
  logic            vblank;
  logic            go;
  axis_t           nx_q;
  axis_t           ny_q;

  assign match  = (x_i == 10'd0) && (y_i == 10'(V_VISIBLE));
  assign vblank = match && !match_q;

`ifdef FRAME_SCHED_STEP_EN
  logic step_arm;
  assign go = run_i || step_arm;
`else
  assign go = run_i;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state     <= S_WAIT;
      frame_cnt <= '0;
      match_q   <= 1'b0;
      x_o       <= '0;
      y_o       <= '0;
      x_dir_o   <= 1'b1;
      y_dir_o   <= 1'b1;
      update_o  <= 1'b0;
      bounce_o  <= 1'b0;
`ifdef FRAME_SCHED_STEP_EN
      step_arm  <= 1'b0;
`endif
    end else begin
      match_q  <= match;
      update_o <= 1'b0;
      bounce_o <= 1'b0;
      case (state)
        S_WAIT: begin
          if (vblank) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt <= '0;
              if (go) state <= S_CALC;
`ifdef FRAME_SCHED_STEP_EN
              if (!run_i) step_arm <= 1'b0;
`endif
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_CALC: state <= S_COMMIT;
        S_COMMIT: begin
          x_o      <= nx_q.pos;
          y_o      <= ny_q.pos;
          x_dir_o  <= nx_q.dir;
          y_dir_o  <= ny_q.dir;
          update_o <= 1'b1;
          bounce_o <= nx_q.flip || ny_q.flip;
          state    <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
`ifdef FRAME_SCHED_STEP_EN
      // A fresh step request wins over one being consumed this cycle.
      if (step_i) step_arm <= 1'b1;
`endif
    end
  end

  // NOTE: the computed next position is only read in S_COMMIT after S_CALC has
  // written it, so these datapath registers carry no reset.
  always_ff @(posedge clk_i) begin
    if (state == S_CALC) begin
      nx_q <= axis_step(x_o, x_dir_o, XMAX);
      ny_q <= axis_step(y_o, y_dir_o, YMAX);
    end
  end

endmodule

// File: tb/tb_frame_motion_sched.sv
// Directed bench for frame_motion_sched: default instance, FRAME_DIV=4 instance, and an
// instance with equal X/Y travel so both axes bounce on the same update.
module tb_frame_motion_sched;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [9:0] x_i = 10'd100;
  logic [9:0] y_i = 10'd100;
  logic       run_a = 1'b1;
  logic       run_b = 1'b1;
  logic       step_i = 1'b0;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic       a_xd, a_yd, a_u, a_b;
  logic       b_xd, b_yd, b_u, b_b;
  logic       c_xd, c_yd, c_u, c_b;

  int vectors = 0;
  int misses  = 0;

  always #5 clk_i = ~clk_i;

  frame_motion_sched dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .x_i(x_i), .y_i(y_i), .run_i(run_a),
`ifdef FRAME_SCHED_STEP_EN
    .step_i(step_i),
`endif
    .x_o(a_x), .y_o(a_y), .x_dir_o(a_xd), .y_dir_o(a_yd), .update_o(a_u), .bounce_o(a_b)
  );

  frame_motion_sched #(.FRAME_DIV(4)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .x_i(x_i), .y_i(y_i), .run_i(run_b),
`ifdef FRAME_SCHED_STEP_EN
    .step_i(step_i),
`endif
    .x_o(b_x), .y_o(b_y), .x_dir_o(b_xd), .y_dir_o(b_yd), .update_o(b_u), .bounce_o(b_b)
  );

  // XMAX = 640-190 = 450 = 480-30 = YMAX: both axes hit their walls on update 450.
  frame_motion_sched #(.OBJ_W(190)) dut_c (
    .clk_i(clk_i), .reset_i(reset_i), .x_i(x_i), .y_i(y_i), .run_i(run_a),
`ifdef FRAME_SCHED_STEP_EN
    .step_i(step_i),
`endif
    .x_o(c_x), .y_o(c_y), .x_dir_o(c_xd), .y_dir_o(c_yd), .update_o(c_u), .bounce_o(c_b)
  );

  function automatic logic [23:0] obs_a();
    return {a_x, a_y, a_xd, a_yd, a_u, a_b};
  endfunction

  function automatic logic [23:0] obs_b();
    return {b_x, b_y, b_xd, b_yd, b_u, b_b};
  endfunction

  function automatic logic [23:0] obs_c();
    return {c_x, c_y, c_xd, c_yd, c_u, c_b};
  endfunction

  function automatic logic [23:0] pack(input int x, input int y, input logic xd,
                                       input logic yd, input logic u, input logic b);
    return {10'(x), 10'(y), xd, yd, u, b};
  endfunction

  // Present the vblank coordinates for exactly one edge (E0); returns at E0+1ns.
  task automatic pulse_event();
    @(posedge clk_i); #1;
    x_i = 10'd0;
    y_i = 10'd480;
    @(posedge clk_i); #1;
    x_i = 10'd100;
    y_i = 10'd100;
  endtask

  // One event, returning at E0+2+1ns, inside the update_o cycle.
  task automatic do_event();
    pulse_event();
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk_i); #2;
    reset_i = 1'b1;
    #5;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    e = pack(0, 0, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL reset_a: got %h want %h", obs_a(), e); misses++; end
    vectors++;
    if (obs_b() !== e) begin $display("FAIL reset_b: got %h want %h", obs_b(), e); misses++; end
    vectors++;
    if (obs_c() !== e) begin $display("FAIL reset_c: got %h want %h", obs_c(), e); misses++; end
  endtask

  task automatic test_basic_motion();
    logic [23:0] e;
    int cnt;
    pulse_event();
    @(posedge clk_i); #1;
    e = pack(0, 0, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL basic_e0p1: got %h want %h", obs_a(), e); misses++; end
    @(posedge clk_i); #1;
    e = pack(1, 1, 1, 1, 1, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL basic_commit: got %h want %h", obs_a(), e); misses++; end
    @(posedge clk_i); #1;
    e = pack(1, 1, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL basic_pulse_end: got %h want %h", obs_a(), e); misses++; end
    // Stalled coordinates: five edges at the vblank point must give a single update.
    cnt = 0;
    x_i = 10'd0;
    y_i = 10'd480;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      cnt += int'(a_u);
    end
    x_i = 10'd100;
    y_i = 10'd100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      cnt += int'(a_u);
    end
    vectors++;
    if (cnt !== 1) begin $display("FAIL stall_updates: got %0d want 1", cnt); misses++; end
    e = pack(2, 2, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL stall_pos: got %h want %h", obs_a(), e); misses++; end
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    int cnt;
    do_event();
    #2;
    reset_i = 1'b1;
    #1;
    e = pack(0, 0, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL async_reset: got %h want %h", obs_a(), e); misses++; end
    #3;
    reset_i = 1'b0;
    // Reset while the update sits in S_CALC: it must be discarded.
    pulse_event();
    #2;
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      cnt += int'(a_u);
    end
    vectors++;
    if (cnt !== 0) begin $display("FAIL discard_updates: got %0d want 0", cnt); misses++; end
    vectors++;
    if (obs_a() !== e) begin $display("FAIL discard_pos: got %h want %h", obs_a(), e); misses++; end
  endtask

  task automatic test_wall_bounce();
    logic [23:0] e;
    int bcnt;
    apply_reset();
    run_a = 1'b1;
    bcnt  = 0;
    for (int k = 1; k <= 449; k++) begin
      do_event();
      bcnt += int'(a_b) + int'(c_b);
    end
    vectors++;
    if (bcnt !== 0) begin $display("FAIL early_bounce: got %0d want 0", bcnt); misses++; end
    e = pack(449, 449, 1, 1, 1, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL ev449_a: got %h want %h", obs_a(), e); misses++; end
    do_event();
    e = pack(450, 450, 1, 0, 1, 1);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL ev450_a: got %h want %h", obs_a(), e); misses++; end
    e = pack(450, 450, 0, 0, 1, 1);
    vectors++;
    if (obs_c() !== e) begin $display("FAIL corner_c: got %h want %h", obs_c(), e); misses++; end
    @(posedge clk_i); #1;
    e = pack(450, 450, 0, 0, 0, 0);
    vectors++;
    if (obs_c() !== e) begin $display("FAIL corner_single: got %h want %h", obs_c(), e); misses++; end
    do_event();
    e = pack(451, 449, 1, 0, 1, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL ev451_a: got %h want %h", obs_a(), e); misses++; end
    e = pack(449, 449, 0, 0, 1, 0);
    vectors++;
    if (obs_c() !== e) begin $display("FAIL ev451_c: got %h want %h", obs_c(), e); misses++; end
    for (int k = 452; k <= 619; k++) do_event();
    e = pack(619, 281, 1, 0, 1, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL ev619_a: got %h want %h", obs_a(), e); misses++; end
    do_event();
    e = pack(620, 280, 0, 0, 1, 1);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL ev620_a: got %h want %h", obs_a(), e); misses++; end
    do_event();
    e = pack(619, 279, 0, 0, 1, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL ev621_a: got %h want %h", obs_a(), e); misses++; end
  endtask

  task automatic test_frame_div();
    logic [23:0] e;
    apply_reset();
    run_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      do_event();
      vectors++;
      if (b_u !== ((k % 4) == 0)) begin
        $display("FAIL div4_ev%0d: got update=%b want %b", k, b_u, (k % 4) == 0);
        misses++;
      end
    end
    e = pack(2, 2, 1, 1, 0, 0);
    @(posedge clk_i); #1;
    vectors++;
    if (obs_b() !== e) begin $display("FAIL div4_pos: got %h want %h", obs_b(), e); misses++; end
    // run low on the 4th event skips that update but the divider keeps counting.
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      run_b = (k != 4);
      do_event();
      vectors++;
      if (b_u !== (k == 8)) begin
        $display("FAIL div4_norun_ev%0d: got update=%b want %b", k, b_u, k == 8);
        misses++;
      end
    end
    run_b = 1'b1;
    e = pack(1, 1, 1, 1, 1, 0);
    vectors++;
    if (obs_b() !== e) begin $display("FAIL div4_norun_pos: got %h want %h", obs_b(), e); misses++; end
  endtask

`ifdef FRAME_SCHED_STEP_EN
  task automatic test_step();
    logic [23:0] e;
    apply_reset();
    run_a = 1'b0;
    @(posedge clk_i); #1;
    step_i = 1'b1;
    @(posedge clk_i); #1;
    step_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      do_event();
      vectors++;
      if (a_u !== (k == 1)) begin
        $display("FAIL step_ev%0d: got update=%b want %b", k, a_u, k == 1);
        misses++;
      end
    end
    e = pack(1, 1, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL step_pos: got %h want %h", obs_a(), e); misses++; end
    @(posedge clk_i); #1;
    step_i = 1'b1;
    @(posedge clk_i); #1;
    step_i = 1'b0;
    apply_reset();
    do_event();
    e = pack(0, 0, 1, 1, 0, 0);
    vectors++;
    if (obs_a() !== e) begin $display("FAIL step_reset: got %h want %h", obs_a(), e); misses++; end
    run_a = 1'b1;
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    test_reset();
    reset_i = 1'b0;
    test_basic_motion();
    test_async_reset();
    test_wall_bounce();
    test_frame_div();
`ifdef FRAME_SCHED_STEP_EN
    test_step();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
